// File: rtl/ffstdp_pkg.sv
// Shared types, widths and index helpers for the FF-STDP update sequencer.
package ffstdp_pkg;

    localparam int unsigned N_PRE_DEF          = 16;
    localparam int unsigned N_POST_DEF         = 16;
    localparam int unsigned PRE_CNT_WIDTH_DEF  = 8;
    localparam int unsigned POST_CNT_WIDTH_DEF = 7;
    localparam int unsigned WEIGHT_WIDTH_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Index width for an array of n entries (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Synapse address width for an n_pre x n_post crossbar.
    function automatic int unsigned syn_aw(input int unsigned n_pre, input int unsigned n_post);
        return idx_w(n_pre * n_post);
    endfunction

endpackage

// File: rtl/spike_count_bank.sv
// Array of saturating spike counters with one increment port, one read port and a synchronous clear.
module spike_count_bank
    import ffstdp_pkg::*;
#(
    parameter  int unsigned N  = 16,
    parameter  int unsigned W  = 8,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic [IW-1:0] inc_idx,
    input  logic          clr,
    input  logic [IW-1:0] rd_idx,
    output logic [W-1:0]  rd_cnt_c
);

    logic [W-1:0] cnt [N];

    // Counters clear on reset or clr; increments stop at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '{default: '0};
        end else if (clr) begin
            cnt <= '{default: '0};
        end else if (inc && (cnt[inc_idx] != '1)) begin
            cnt[inc_idx] <= cnt[inc_idx] + W'(1);
        end
    end

    assign rd_cnt_c = cnt[rd_idx];

endmodule

// File: rtl/ffstdp_update_sequencer.sv
// Counts spikes over a sample window, then sweeps every synapse through the update rule.
module ffstdp_update_sequencer
    import ffstdp_pkg::*;
#(
    parameter  int unsigned N_PRE          = N_PRE_DEF,
    parameter  int unsigned N_POST         = N_POST_DEF,
    parameter  int unsigned PRE_CNT_WIDTH  = PRE_CNT_WIDTH_DEF,
    parameter  int unsigned POST_CNT_WIDTH = POST_CNT_WIDTH_DEF,
    parameter  int unsigned WEIGHT_WIDTH   = WEIGHT_WIDTH_DEF,
    localparam int unsigned SYN_AW         = syn_aw(N_PRE, N_POST),
    localparam int unsigned PRE_AW         = idx_w(N_PRE),
    localparam int unsigned POST_AW        = idx_w(N_POST)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      is_train,
    input  logic                      is_pos,
    input  logic                      ctrl_tref_event,
    input  logic                      pre_spike_valid,
    input  logic [PRE_AW-1:0]         pre_spike_addr,
    input  logic                      post_spike_valid,
    input  logic [POST_AW-1:0]        post_spike_addr,
    output logic                      syn_re,
    output logic                      syn_we,
    output logic [SYN_AW-1:0]         syn_addr,
    input  logic [WEIGHT_WIDTH-1:0]   syn_rdata,
    output logic [WEIGHT_WIDTH-1:0]   syn_wdata,
    output logic [PRE_CNT_WIDTH-1:0]  upd_pre_cnt,
    output logic [POST_CNT_WIDTH-1:0] upd_post_cnt,
    output logic [WEIGHT_WIDTH-1:0]   upd_wsyn_curr,
    output logic                      upd_is_pos,
    output logic                      upd_is_train,
    output logic                      upd_ctrl_tref_event,
    input  logic [WEIGHT_WIDTH-1:0]   upd_wsyn_new,
    output logic                      busy,
    output logic                      done
);

    state_t               state, state_n;
    logic [PRE_AW-1:0]    pre_idx, pre_n;
    logic [POST_AW-1:0]   post_idx, post_n;
    logic [SYN_AW-1:0]    addr_n;
    logic                 latch_label;
    logic                 pre_inc, post_inc, cnt_clr;
    logic [PRE_CNT_WIDTH-1:0]  pre_rd;
    logic [POST_CNT_WIDTH-1:0] post_rd;

    spike_count_bank #(.N(N_PRE), .W(PRE_CNT_WIDTH)) u_pre_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (pre_inc),
        .inc_idx  (pre_spike_addr),
        .clr      (cnt_clr),
        .rd_idx   (pre_n),
        .rd_cnt_c (pre_rd)
    );

    spike_count_bank #(.N(N_POST), .W(POST_CNT_WIDTH)) u_post_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (post_inc),
        .inc_idx  (post_spike_addr),
        .clr      (cnt_clr),
        .rd_idx   (post_n),
        .rd_cnt_c (post_rd)
    );

    // Next state, sweep index walk (pre fastest) and counter control.
    always_comb begin
        state_n     = state;
        pre_n       = pre_idx;
        post_n      = post_idx;
        latch_label = 1'b0;
        pre_inc     = 1'b0;
        post_inc    = 1'b0;
        cnt_clr     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                pre_inc  = pre_spike_valid;
                post_inc = post_spike_valid;
                if (ctrl_tref_event) begin
                    latch_label = 1'b1;
                    pre_n       = '0;
                    post_n      = '0;
                    state_n     = is_train ? ST_READ : ST_FINISH;
                end
            end
            ST_READ: begin
                state_n = ST_WRITE;
            end
            ST_WRITE: begin
                state_n = ST_READ;
                if (pre_idx == PRE_AW'(N_PRE - 1)) begin
                    pre_n = '0;
                    if (post_idx == POST_AW'(N_POST - 1)) begin
                        post_n  = '0;
                        state_n = ST_FINISH;
                    end else begin
                        post_n = post_idx + POST_AW'(1);
                    end
                end else begin
                    pre_n = pre_idx + PRE_AW'(1);
                end
            end
            ST_FINISH: begin
                cnt_clr = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        addr_n = SYN_AW'(int'(post_n) * int'(N_PRE) + int'(pre_n));
    end

    // State register plus strobes and update-rule operands registered off the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            pre_idx             <= '0;
            post_idx            <= '0;
            upd_is_pos          <= 1'b0;
            upd_is_train        <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            syn_re              <= 1'b0;
            syn_we              <= 1'b0;
            upd_ctrl_tref_event <= 1'b0;
            syn_addr            <= '0;
            upd_pre_cnt         <= '0;
            upd_post_cnt        <= '0;
        end else begin
            state    <= state_n;
            pre_idx  <= pre_n;
            post_idx <= post_n;
            if (latch_label) begin
                upd_is_pos   <= is_pos;
                upd_is_train <= is_train;
            end
            busy                <= (state_n != ST_IDLE);
            done                <= (state_n == ST_FINISH);
            syn_re              <= (state_n == ST_READ);
            syn_we              <= (state_n == ST_WRITE);
            upd_ctrl_tref_event <= (state_n == ST_WRITE);
            syn_addr            <= ((state_n == ST_READ) || (state_n == ST_WRITE)) ? addr_n : '0;
            upd_pre_cnt         <= (state_n == ST_WRITE) ? pre_rd  : '0;
            upd_post_cnt        <= (state_n == ST_WRITE) ? post_rd : '0;
        end
    end

    // Weight path stays combinational through the update rule within the write cycle.
    assign upd_wsyn_curr = syn_we ? syn_rdata    : '0;
    assign syn_wdata     = syn_we ? upd_wsyn_new : '0;

endmodule

// File: tb/tb_ffstdp_update_sequencer.sv
// Directed bench for the FF-STDP update sequencer with a behavioural synapse SRAM and +1 update rule.
module tb_ffstdp_update_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       is_train, is_pos, ctrl_tref_event;
    logic       pre_spike_valid, post_spike_valid;
    logic [3:0] pre_spike_addr, post_spike_addr;
    logic       syn_re, syn_we;
    logic [7:0] syn_addr;
    logic [7:0] syn_rdata = 8'd0;
    logic [7:0] syn_wdata;
    logic [7:0] upd_pre_cnt;
    logic [6:0] upd_post_cnt;
    logic [7:0] upd_wsyn_curr, upd_wsyn_new;
    logic       upd_is_pos, upd_is_train, upd_ctrl_tref_event;
    logic       busy, done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [256];
    logic       preload = 1'b0;
    logic [7:0] preload_val = 8'd0;

    logic [7:0] got_pre  [256];
    logic [6:0] got_post [256];
    int         nwr      [256];
    int done_cnt, re_cnt, we_cnt, order_err, side_err, latency;
    bit aborted;
    logic got_pos, got_train;

    always #5 clk = ~clk;

    ffstdp_update_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .is_train            (is_train),
        .is_pos              (is_pos),
        .ctrl_tref_event     (ctrl_tref_event),
        .pre_spike_valid     (pre_spike_valid),
        .pre_spike_addr      (pre_spike_addr),
        .post_spike_valid    (post_spike_valid),
        .post_spike_addr     (post_spike_addr),
        .syn_re              (syn_re),
        .syn_we              (syn_we),
        .syn_addr            (syn_addr),
        .syn_rdata           (syn_rdata),
        .syn_wdata           (syn_wdata),
        .upd_pre_cnt         (upd_pre_cnt),
        .upd_post_cnt        (upd_post_cnt),
        .upd_wsyn_curr       (upd_wsyn_curr),
        .upd_is_pos          (upd_is_pos),
        .upd_is_train        (upd_is_train),
        .upd_ctrl_tref_event (upd_ctrl_tref_event),
        .upd_wsyn_new        (upd_wsyn_new),
        .busy                (busy),
        .done                (done)
    );

    // Update rule stand-in: new weight is the read weight plus one.
    assign upd_wsyn_new = syn_rdata + 8'd1;

    // Synapse SRAM: one-cycle read latency, synchronous write.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= preload_val;
        end else begin
            if (syn_we) mem[syn_addr] <= syn_wdata;
            if (syn_re) syn_rdata <= mem[syn_addr];
        end
    end

    task automatic do_preload(input logic [7:0] v);
        preload_val = v;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    task automatic spikes(input int npre, input int pa, input int npost, input int pb);
        int n;
        n = (npre > npost) ? npre : npost;
        for (int i = 0; i < n; i++) begin
            pre_spike_valid  = (i < npre);
            pre_spike_addr   = 4'(pa);
            post_spike_valid = (i < npost);
            post_spike_addr  = 4'(pb);
            @(negedge clk);
        end
        pre_spike_valid  = 1'b0;
        post_spike_valid = 1'b0;
    endtask

    // Fires one window end and records what the sequencer presents on every cycle of the sweep.
    task automatic run_window(input bit train, input bit pos, input bit noise,
                              input int stop_addr, input int coinc_pre);
        int nxt;
        nxt = 0;
        for (int a = 0; a < 256; a++) begin
            got_pre[a] = '0; got_post[a] = '0; nwr[a] = 0;
        end
        done_cnt = 0; re_cnt = 0; we_cnt = 0; order_err = 0; side_err = 0;
        latency = -1; aborted = 1'b0; got_pos = 1'b0; got_train = 1'b0;
        ctrl_tref_event = 1'b1; is_train = train; is_pos = pos;
        if (coinc_pre >= 0) begin
            pre_spike_valid = 1'b1;
            pre_spike_addr  = 4'(coinc_pre);
        end
        @(negedge clk);
        ctrl_tref_event = 1'b0;
        pre_spike_valid = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            if (syn_re) begin
                re_cnt++;
                if (int'(syn_addr) == stop_addr) begin
                    rst_n = 1'b0;
                    aborted = 1'b1;
                    return;
                end
            end
            if (syn_we) begin
                we_cnt++;
                if (int'(syn_addr) != nxt) order_err++;
                nxt++;
                nwr[syn_addr]++;
                got_pre[syn_addr]  = upd_pre_cnt;
                got_post[syn_addr] = upd_post_cnt;
                got_pos   = upd_is_pos;
                got_train = upd_is_train;
                if (upd_wsyn_curr !== syn_rdata || upd_ctrl_tref_event !== 1'b1) side_err++;
            end else if (upd_ctrl_tref_event !== 1'b0 || upd_wsyn_curr !== 8'd0) begin
                side_err++;
            end
            if (done) begin
                done_cnt++;
                if (latency < 0) latency = cyc;
            end
            if (latency >= 0 && !busy) return;
            pre_spike_valid  = noise && cyc >= 2 && cyc <= 6;
            post_spike_valid = noise && cyc >= 2 && cyc <= 6;
            pre_spike_addr   = 4'd7;
            post_spike_addr  = 4'd2;
            ctrl_tref_event  = noise && cyc == 30;
            @(negedge clk);
        end
        pre_spike_valid  = 1'b0;
        post_spike_valid = 1'b0;
        ctrl_tref_event  = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
        vectors++; if (syn_re !== 1'b0 || syn_we !== 1'b0) begin miscompares++; $display("FAIL rst_strobes got re=%b we=%b want 0 0", syn_re, syn_we); end
        vectors++; if (syn_addr !== 8'd0) begin miscompares++; $display("FAIL rst_addr got %0d want 0", syn_addr); end
        vectors++; if (syn_wdata !== 8'd0) begin miscompares++; $display("FAIL rst_wdata got %0d want 0", syn_wdata); end
        vectors++; if (upd_pre_cnt !== 8'd0 || upd_post_cnt !== 7'd0) begin miscompares++; $display("FAIL rst_upd_cnt got %0d/%0d want 0/0", upd_pre_cnt, upd_post_cnt); end
        vectors++; if (upd_is_pos !== 1'b0 || upd_is_train !== 1'b0 || upd_ctrl_tref_event !== 1'b0) begin miscompares++; $display("FAIL rst_upd_flags got %b%b%b want 000", upd_is_pos, upd_is_train, upd_ctrl_tref_event); end
        vectors++; if (upd_wsyn_curr !== 8'd0) begin miscompares++; $display("FAIL rst_wcurr got %0d want 0", upd_wsyn_curr); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0 || syn_re !== 1'b0) begin miscompares++; $display("FAIL post_rst_idle got busy=%b re=%b want 0 0", busy, syn_re); end
    endtask

    task automatic test_counting();
        do_preload(8'd50);
        spikes(3, 2, 5, 1);
        run_window(1'b1, 1'b1, 1'b0, -1, -1);
        vectors++; if (got_pre[18] !== 8'd3) begin miscompares++; $display("FAIL cnt_pre_a18 got %0d want 3", got_pre[18]); end
        vectors++; if (got_post[18] !== 7'd5) begin miscompares++; $display("FAIL cnt_post_a18 got %0d want 5", got_post[18]); end
        for (int a = 0; a < 256; a++) begin
            logic [7:0] ep;
            logic [6:0] eq;
            ep = (a % 16 == 2) ? 8'd3 : 8'd0;
            eq = (a / 16 == 1) ? 7'd5 : 7'd0;
            vectors++; if (got_pre[a] !== ep) begin miscompares++; $display("FAIL cnt_pre a=%0d got %0d want %0d", a, got_pre[a], ep); end
            vectors++; if (got_post[a] !== eq) begin miscompares++; $display("FAIL cnt_post a=%0d got %0d want %0d", a, got_post[a], eq); end
        end
        vectors++; if (got_pos !== 1'b1 || got_train !== 1'b1) begin miscompares++; $display("FAIL cnt_labels got pos=%b train=%b want 1 1", got_pos, got_train); end
    endtask

    task automatic test_full_sweep();
        do_preload(8'd50);
        run_window(1'b1, 1'b1, 1'b0, -1, -1);
        vectors++; if (latency != 513) begin miscompares++; $display("FAIL sweep_latency got %0d want 513", latency); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL sweep_done_count got %0d want 1", done_cnt); end
        vectors++; if (order_err != 0 || we_cnt != 256) begin miscompares++; $display("FAIL sweep_order got errs=%0d writes=%0d want 0 256", order_err, we_cnt); end
        vectors++; if (re_cnt != 256) begin miscompares++; $display("FAIL sweep_reads got %0d want 256", re_cnt); end
        vectors++; if (side_err != 0) begin miscompares++; $display("FAIL sweep_upd_side got %0d errs want 0", side_err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sweep_busy_after got %b want 0", busy); end
        for (int a = 0; a < 256; a++) begin
            vectors++; if (nwr[a] != 1 || mem[a] !== 8'd51) begin miscompares++; $display("FAIL sweep_write a=%0d got n=%0d w=%0d want 1 51", a, nwr[a], mem[a]); end
            vectors++; if (got_pre[a] !== 8'd0 || got_post[a] !== 7'd0) begin miscompares++; $display("FAIL sweep_cleared a=%0d got %0d/%0d want 0/0", a, got_pre[a], got_post[a]); end
        end
    endtask

    task automatic test_saturation();
        spikes(300, 0, 200, 0);
        run_window(1'b1, 1'b1, 1'b0, -1, -1);
        vectors++; if (got_pre[0] !== 8'd255) begin miscompares++; $display("FAIL sat_pre got %0d want 255", got_pre[0]); end
        vectors++; if (got_post[0] !== 7'd127) begin miscompares++; $display("FAIL sat_post got %0d want 127", got_post[0]); end
        vectors++; if (got_pre[16] !== 8'd255) begin miscompares++; $display("FAIL sat_pre_a16 got %0d want 255", got_pre[16]); end
        vectors++; if (got_post[1] !== 7'd127) begin miscompares++; $display("FAIL sat_post_a1 got %0d want 127", got_post[1]); end
        vectors++; if (got_pre[1] !== 8'd0 || got_post[16] !== 7'd0) begin miscompares++; $display("FAIL sat_neighbour got %0d/%0d want 0/0", got_pre[1], got_post[16]); end
    endtask

    task automatic test_no_train();
        spikes(2, 3, 2, 4);
        run_window(1'b0, 1'b1, 1'b0, -1, -1);
        vectors++; if (latency != 1) begin miscompares++; $display("FAIL notrain_latency got %0d want 1", latency); end
        vectors++; if (re_cnt != 0 || we_cnt != 0) begin miscompares++; $display("FAIL notrain_sram got re=%0d we=%0d want 0 0", re_cnt, we_cnt); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL notrain_done_count got %0d want 1", done_cnt); end
        vectors++; if (upd_is_train !== 1'b0) begin miscompares++; $display("FAIL notrain_flag got %b want 0", upd_is_train); end
        run_window(1'b1, 1'b0, 1'b0, -1, -1);
        vectors++; if (got_pre[3] !== 8'd0 || got_pre[83] !== 8'd0) begin miscompares++; $display("FAIL notrain_pre_cleared got %0d/%0d want 0/0", got_pre[3], got_pre[83]); end
        vectors++; if (got_post[64] !== 7'd0) begin miscompares++; $display("FAIL notrain_post_cleared got %0d want 0", got_post[64]); end
    endtask

    task automatic test_collisions();
        run_window(1'b1, 1'b0, 1'b1, -1, 5);
        vectors++; if (got_pre[5] !== 8'd1 || got_pre[245] !== 8'd1) begin miscompares++; $display("FAIL coll_coinc got %0d/%0d want 1/1", got_pre[5], got_pre[245]); end
        vectors++; if (got_pre[55] !== 8'd0 || got_pre[247] !== 8'd0) begin miscompares++; $display("FAIL coll_busy_pre got %0d/%0d want 0/0", got_pre[55], got_pre[247]); end
        vectors++; if (got_post[32] !== 7'd0 || got_post[47] !== 7'd0) begin miscompares++; $display("FAIL coll_busy_post got %0d/%0d want 0/0", got_post[32], got_post[47]); end
        vectors++; if (done_cnt != 1 || latency != 513) begin miscompares++; $display("FAIL coll_done got n=%0d lat=%0d want 1 513", done_cnt, latency); end
        vectors++; if (got_pos !== 1'b0) begin miscompares++; $display("FAIL coll_label got %b want 0", got_pos); end
        repeat (4) @(negedge clk);
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || syn_re !== 1'b0) begin miscompares++; $display("FAIL coll_quiet got busy=%b done=%b re=%b want 0 0 0", busy, done, syn_re); end
    endtask

    task automatic test_reset_mid();
        do_preload(8'd50);
        spikes(4, 1, 0, 0);
        run_window(1'b1, 1'b1, 1'b0, 100, -1);
        #1;
        vectors++; if (!aborted) begin miscompares++; $display("FAIL rmid_reached got 0 want 1"); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b/%b want 0/0", busy, done); end
        vectors++; if (syn_re !== 1'b0 || syn_we !== 1'b0 || syn_addr !== 8'd0) begin miscompares++; $display("FAIL rmid_sram got re=%b we=%b addr=%0d want 0 0 0", syn_re, syn_we, syn_addr); end
        vectors++; if (upd_pre_cnt !== 8'd0 || upd_ctrl_tref_event !== 1'b0) begin miscompares++; $display("FAIL rmid_upd got %0d/%b want 0/0", upd_pre_cnt, upd_ctrl_tref_event); end
        repeat (2) @(negedge clk);
        for (int a = 0; a < 256; a++) begin
            logic [7:0] ew;
            ew = (a < 100) ? 8'd51 : 8'd50;
            vectors++; if (mem[a] !== ew) begin miscompares++; $display("FAIL rmid_mem a=%0d got %0d want %0d", a, mem[a], ew); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_window(1'b1, 1'b1, 1'b0, -1, -1);
        vectors++; if (got_pre[1] !== 8'd0 || got_pre[17] !== 8'd0) begin miscompares++; $display("FAIL rmid_cleared got %0d/%0d want 0/0", got_pre[1], got_pre[17]); end
        vectors++; if (done_cnt != 1 || latency != 513) begin miscompares++; $display("FAIL rmid_resweep got n=%0d lat=%0d want 1 513", done_cnt, latency); end
    endtask

    initial begin
        rst_n = 1'b0;
        is_train = 1'b0; is_pos = 1'b0; ctrl_tref_event = 1'b0;
        pre_spike_valid = 1'b0; post_spike_valid = 1'b0;
        pre_spike_addr = 4'd0; post_spike_addr = 4'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_counting();
        test_full_sweep();
        test_saturation();
        test_no_train();
        test_collisions();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ffstdp_update_sequencer.md
# ffstdp_update_sequencer

Drives the FF-STDP weight-update sweep at the end of each sample window. Accumulates per-input pre-spike counts and per-neuron post-spike counts during the window. On the end-of-window event it walks every synapse: reads the weight from synapse SRAM, presents counts and weight to the combinational update rule, and writes the returned weight back. It is the reader/writer on the far side of the update-rule interface, sitting between the spike router, the synapse memory and the update datapath.

## Interface
- N_PRE, 16: number of pre-synaptic inputs.
- N_POST, 16: number of post-synaptic neurons.
- PRE_CNT_WIDTH, 8: pre-spike counter width.
- POST_CNT_WIDTH, 7: post-spike counter width.
- WEIGHT_WIDTH, 8: signed synaptic weight width.
- SYN_AW, $clog2(N_PRE*N_POST): synapse address width (derived).

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- IS_TRAIN  in  1  training enable, sampled with CTRL_TREF_EVENT.
- IS_POS  in  1  positive/negative sample label, sampled with CTRL_TREF_EVENT.
- CTRL_TREF_EVENT  in  1  end-of-window pulse.
- PRE_SPIKE_VALID / PRE_SPIKE_ADDR  in  1 / $clog2(N_PRE)  input spike event.
- POST_SPIKE_VALID / POST_SPIKE_ADDR  in  1 / $clog2(N_POST)  neuron spike event.
- SYN_RE, SYN_WE  out  1  synapse SRAM read/write strobes.
- SYN_ADDR  out  SYN_AW  synapse address, post*N_PRE+pre.
- SYN_RDATA  in  WEIGHT_WIDTH  read data, valid one cycle after SYN_RE.
- SYN_WDATA  out  WEIGHT_WIDTH  write data.
- UPD_PRE_CNT / UPD_POST_CNT  out  PRE_CNT_WIDTH / POST_CNT_WIDTH  counts to update rule.
- UPD_WSYN_CURR  out  WEIGHT_WIDTH  current weight to update rule, equal to SYN_RDATA.
- UPD_IS_POS, UPD_IS_TRAIN, UPD_CTRL_TREF_EVENT  out  1  latched label; train flag; high in WRITE.
- UPD_WSYN_NEW  in  WEIGHT_WIDTH  combinational result from update rule.
- BUSY  out  1  sweep in progress.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, READ, WRITE, FINISH.
- IDLE: count spikes.
  - A valid spike increments the addressed counter.
  - Counters saturate at all-ones; no wrap.
  - PRE and POST events in the same cycle are both counted.
- Window end: CTRL_TREF_EVENT in IDLE latches IS_POS and IS_TRAIN.
  - IS_TRAIN=1: go to READ with pre=0, post=0.
  - IS_TRAIN=0: go to FINISH directly; no SRAM access.
- READ: SYN_RE=1, SYN_ADDR=post*N_PRE+pre → WRITE.
- WRITE: drive UPD_* from cnt_pre[pre], cnt_post[post] and SYN_RDATA.
  - SYN_WE=1 at the same address, SYN_WDATA=UPD_WSYN_NEW.
  - Advance the index, pre fastest.
  - If the index was (N_POST-1, N_PRE-1) → FINISH, else → READ.
- FINISH: clear all counters, DONE=1 → IDLE.
- Spike arriving in the same cycle as CTRL_TREF_EVENT: counted into the closing window.
- Spikes while BUSY: dropped.
- CTRL_TREF_EVENT while BUSY: ignored.
- Reset mid-sweep: return to IDLE with counters cleared. Weights already written stay written. No partial write is issued after reset assertion.

## Timing
- Reset values: all strobes, UPD_*, SYN_ADDR, SYN_WDATA, BUSY, DONE = 0. FSM in IDLE, all counters 0.
- Sweep start: TREF sampled at edge t0 → BUSY=1 and READ during cycle t0+1.
- Throughput: 2 cycles per synapse.
- Completion: DONE at cycle t0+2·N_PRE·N_POST+1. BUSY falls when the FSM leaves FINISH.
- Non-train window: DONE at t0+1.
- Update path: combinational SYN_RDATA → update rule → SYN_WDATA within the WRITE cycle. There is no register on this path.

## Structure
- Package ffstdp_pkg holds:
  - the state enum;
  - the SYN_AW / index-width helper functions;
  - shared width defaults matching the update rule.
- One sub-module, spike_count_bank: a parameterised array of saturating counters with increment port, read index and synchronous clear. Instantiated twice (pre, post).

## Test plan
- Counting: 3 spikes on pre 2, 5 on post 1, TREF with IS_TRAIN=1 → in the WRITE cycle for address 1·16+2=18, UPD_PRE_CNT=3 and UPD_POST_CNT=5. All other addresses show the matching zero counts.
- Saturation: 300 spikes on pre 0 → UPD_PRE_CNT=255. 200 spikes on post 0 → UPD_POST_CNT=127.
- Full sweep with a loopback model where UPD_WSYN_NEW=SYN_RDATA+1 and all weights 50:
  - every address is written with 51 exactly once, in order 0..255;
  - DONE arrives 513 cycles after TREF;
  - counters read 0 afterwards.
- IS_TRAIN=0: TREF → no SYN_RE/SYN_WE; DONE at the next cycle; counters cleared.
- Collisions: spike coincident with TREF is counted; spikes and a second TREF during BUSY are ignored; exactly one DONE.
- Reset at address 100 mid-sweep: RST_N low → outputs 0 immediately, FSM in IDLE, addresses ≥100 untouched, counters 0.
